// File: rtl/bsg_link_sched_pkg.sv
// Shared types for the DDR link schedulers.
// FSM encoding and credit counter sizing.
package bsg_link_sched_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    IDLE     = 2'd1,
    HOLD     = 2'd2
  } sched_state_e;

  // Counter must hold the full 2^lg_depth value.
  function automatic int credit_width(input int lg_depth);
    return lg_depth + 1;
  endfunction

endpackage

// File: rtl/bsg_link_upstream_sched_if.sv
// Requester and upstream-link handshake bundle.
// master = scheduler side, slave = core/link side.
interface bsg_link_upstream_sched_if #(
  parameter int num_req_p = 4,
  parameter int width_p   = 64
);

  logic [num_req_p-1:0]         req_valid_i;
  logic [num_req_p*width_p-1:0] req_data_i;
  logic [num_req_p-1:0]         req_ready_o;
  logic                         link_valid_o;
  logic [width_p-1:0]           link_data_o;
  logic                         link_ready_i;

  modport master (
    input  req_valid_i,
    input  req_data_i,
    input  link_ready_i,
    output req_ready_o,
    output link_valid_o,
    output link_data_o
  );

  modport slave (
    output req_valid_i,
    output req_data_i,
    output link_ready_i,
    input  req_ready_o,
    input  link_valid_o,
    input  link_data_o
  );

endinterface

// File: rtl/bsg_link_rr_arb.sv
// Combinational round-robin arbiter: first valid at or
// after ptr_i, wrapping, as one-hot plus encoded id.
module bsg_link_rr_arb #(
  parameter int num_req_p = 4
) (
  input  logic [num_req_p-1:0]         valid_i,
  input  logic [$clog2(num_req_p)-1:0] ptr_i,
  output logic [num_req_p-1:0]         grant_oh_o,
  output logic [$clog2(num_req_p)-1:0] grant_id_o,
  output logic                         any_o
);

  localparam int id_w_lp = $clog2(num_req_p);

  int   idx;
  logic found;

  always_comb begin
    grant_oh_o = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = 0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= num_req_p)
        idx = idx - num_req_p;
      if (!found && valid_i[idx]) begin
        found           = 1'b1;
        grant_oh_o[idx] = 1'b1;
        grant_id_o      = id_w_lp'(idx);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/bsg_link_upstream_sched.sv
// Credit-gated round-robin scheduler feeding one
// upstream DDR link from num_req_p core requesters.
module bsg_link_upstream_sched
  import bsg_link_sched_pkg::*;
#(
  parameter int num_req_p                       = 4,
  parameter int width_p                         = 64,
  parameter int lg_fifo_depth_p                 = 6,
  parameter int lg_credit_to_token_decimation_p = 3
) (
  input  logic core_clk_i,
  input  logic core_reset_n_i,
  input  logic link_enable_i,
  input  logic token_i,
  bsg_link_upstream_sched_if.master bus,
  output logic [credit_width(lg_fifo_depth_p)-1:0] credits_o,
  output logic [$clog2(num_req_p)-1:0] grant_id_o,
  output logic overflow_o
);

  localparam int cw_lp   = credit_width(lg_fifo_depth_p);
  localparam int id_w_lp = $clog2(num_req_p);
  localparam logic [cw_lp-1:0] max_lp =
    cw_lp'(2 ** lg_fifo_depth_p);
  localparam logic [cw_lp:0] tok_lp =
    (cw_lp + 1)'(2 ** lg_credit_to_token_decimation_p);
  localparam logic [id_w_lp-1:0] last_id_lp =
    id_w_lp'(num_req_p - 1);

  sched_state_e state_q, state_d;

  logic [id_w_lp-1:0] ptr_q, nxt_id, arb_ptr, arb_id;
  logic [num_req_p-1:0] arb_oh;
  logic arb_any, held, send, eligible, grant;
  logic [cw_lp:0] cred_sum;
  logic cred_ovf;

  assign held   = (state_q == HOLD);
  assign send   = held & bus.link_ready_i;
  assign nxt_id = (grant_id_o == last_id_lp) ?
                  '0 : grant_id_o + 1'b1;
  // Back-to-back grants rotate past the word leaving now.
  assign arb_ptr = held ? nxt_id : ptr_q;

  // The held word already owns one credit.
  assign eligible = arb_any & link_enable_i &
                    (credits_o > cw_lp'(held));

  bsg_link_rr_arb #(.num_req_p(num_req_p)) arb (
    .valid_i    (bus.req_valid_i),
    .ptr_i      (arb_ptr),
    .grant_oh_o (arb_oh),
    .grant_id_o (arb_id),
    .any_o      (arb_any)
  );

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) state_q <= DISABLED;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DISABLED: if (link_enable_i) state_d = IDLE;
      IDLE: begin
        if (!link_enable_i) state_d = DISABLED;
        else if (eligible)  state_d = HOLD;
      end
      HOLD: begin
        if (send)
          state_d = eligible      ? HOLD :
                    link_enable_i ? IDLE : DISABLED;
      end
      default: state_d = DISABLED;
    endcase
  end

  always_comb begin
    grant           = eligible & ((state_q == IDLE) | send);
    bus.req_ready_o = grant ? arb_oh : '0;
  end

  assign cred_sum = {1'b0, credits_o}
                  + (token_i ? tok_lp : '0)
                  - (cw_lp + 1)'(send);
  assign cred_ovf = (cred_sum > {1'b0, max_lp});

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      bus.link_valid_o <= 1'b0;
      bus.link_data_o  <= '0;
      grant_id_o       <= '0;
      ptr_q            <= '0;
      credits_o        <= max_lp;
      overflow_o       <= 1'b0;
    end else begin
      if (grant) begin
        bus.link_valid_o <= 1'b1;
        bus.link_data_o  <=
          bus.req_data_i[int'(arb_id)*width_p +: width_p];
        grant_id_o       <= arb_id;
      end else if (send) begin
        bus.link_valid_o <= 1'b0;
      end
      if (send) ptr_q <= nxt_id;
      credits_o <= cred_ovf ? max_lp : cred_sum[cw_lp-1:0];
      if (cred_ovf) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_link_upstream_sched.sv
// Directed bench for bsg_link_upstream_sched with a
// scoreboard tracking accepted words to the link.
module tb_bsg_link_upstream_sched;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic tok = 1'b0;
  logic [6:0] credits;
  logic [1:0] gid;
  logic ovf;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  exp_t sb[$];

  bsg_link_upstream_sched_if #(
    .num_req_p(4), .width_p(64)) bus ();

  bsg_link_upstream_sched #(
    .num_req_p(4),
    .width_p(64),
    .lg_fifo_depth_p(6),
    .lg_credit_to_token_decimation_p(3)
  ) dut (
    .core_clk_i     (clk),
    .core_reset_n_i (rst_n),
    .link_enable_i  (en),
    .token_i        (tok),
    .bus            (bus),
    .credits_o      (credits),
    .grant_id_o     (gid),
    .overflow_o     (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_data(input int i, input logic [63:0] d);
    bus.req_data_i[i*64 +: 64] = d;
  endtask

  always @(negedge rst_n) sb.delete();

  // Scoreboard: push on accept, pop on link handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_ready_o != 4'b0) begin
        check("ready_onehot",
              64'($countones(bus.req_ready_o)), 64'd1);
        for (int i = 0; i < 4; i++)
          if (bus.req_ready_o[i])
            sb.push_back('{id: 2'(i),
                           data: bus.req_data_i[i*64 +: 64]});
      end
      if (bus.link_valid_o && bus.link_ready_i) begin
        check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_data", bus.link_data_o, e.data);
          check("sb_id", 64'(gid), 64'(e.id));
        end
      end
    end
  end

  initial begin
    int n;
    bus.req_valid_i  = 4'b0;
    bus.req_data_i   = '0;
    bus.link_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      set_data(i, 64'h100 + 64'(i));

    // Reset values
    #12;
    check("rst_credits", 64'(credits), 64'd64);
    check("rst_valid", 64'(bus.link_valid_o), 64'd0);
    check("rst_data", bus.link_data_o, 64'd0);
    check("rst_gid", 64'(gid), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_ready", 64'(bus.req_ready_o), 64'd0);
    cyc();
    rst_n = 1'b1;

    // Single word from requester 0
    cyc();
    en = 1'b1;
    bus.link_ready_i = 1'b1;
    cyc();
    bus.req_valid_i = 4'b0001;
    set_data(0, 64'hA5);
    settle();
    check("t0_ready", 64'(bus.req_ready_o), 64'h1);
    cyc();
    bus.req_valid_i = 4'b0;
    settle();
    check("t1_valid", 64'(bus.link_valid_o), 64'd1);
    check("t1_data", bus.link_data_o, 64'hA5);
    check("t1_credits", 64'(credits), 64'd64);
    cyc();
    settle();
    check("t2_credits", 64'(credits), 64'd63);
    check("t2_valid", 64'(bus.link_valid_o), 64'd0);

    // All four valid: rotation from pointer 1
    cyc();
    bus.req_valid_i = 4'b1111;
    settle();
    check("rr_first", 64'(bus.req_ready_o), 64'h2);
    for (int k = 0; k < 8; k++) begin
      cyc();
      settle();
      check("rr_gid", 64'(gid), 64'((1 + k) % 4));
      check("rr_valid", 64'(bus.link_valid_o), 64'd1);
    end

    // Drain credits
    n = 0;
    while (credits != 7'd0 && n < 100) begin
      cyc();
      settle();
      n++;
    end
    check("drain_zero", 64'(credits), 64'd0);
    check("drain_valid", 64'(bus.link_valid_o), 64'd0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      settle();
      check("starve_ready", 64'(bus.req_ready_o), 64'd0);
      check("starve_cred", 64'(credits), 64'd0);
    end
    cyc();
    tok = 1'b1;
    settle();
    check("tok_ready", 64'(bus.req_ready_o), 64'd0);
    cyc();
    tok = 1'b0;
    settle();
    check("tok_credits", 64'(credits), 64'd8);
    check("resume", 64'(|bus.req_ready_o), 64'd1);
    cyc();
    bus.req_valid_i = 4'b0;
    settle();
    check("resume_valid", 64'(bus.link_valid_o), 64'd1);
    cyc();
    settle();
    check("resume_cred", 64'(credits), 64'd7);

    // Backpressure for five cycles
    cyc();
    bus.link_ready_i = 1'b0;
    bus.req_valid_i = 4'b0010;
    set_data(1, 64'hDEAD_BEEF);
    settle();
    check("bp_ready", 64'(bus.req_ready_o), 64'h2);
    cyc();
    bus.req_valid_i = 4'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(bus.link_valid_o), 64'd1);
      check("bp_data", bus.link_data_o, 64'hDEAD_BEEF);
      check("bp_gid", 64'(gid), 64'd1);
      check("bp_cred", 64'(credits), 64'd7);
      cyc();
      settle();
    end
    bus.link_ready_i = 1'b1;
    settle();
    check("bp_last", 64'(bus.link_valid_o), 64'd1);
    cyc();
    settle();
    check("bp_cred_dec", 64'(credits), 64'd6);
    check("bp_done", 64'(bus.link_valid_o), 64'd0);

    // Overflow at full credit, then token+send
    rst_n = 1'b0;
    #1;
    check("rst2_credits", 64'(credits), 64'd64);
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    tok = 1'b1;
    settle();
    cyc();
    tok = 1'b0;
    settle();
    check("ovf_cred", 64'(credits), 64'd64);
    check("ovf_set", 64'(ovf), 64'd1);
    cyc();
    settle();
    check("ovf_sticky", 64'(ovf), 64'd1);
    bus.req_valid_i = 4'b1111;
    n = 0;
    while (!(credits == 7'd10 && bus.link_valid_o)
           && n < 100) begin
      cyc();
      settle();
      n++;
    end
    check("at_ten", 64'(credits), 64'd10);
    tok = 1'b1;
    bus.req_valid_i = 4'b0;
    cyc();
    tok = 1'b0;
    settle();
    check("tok_send", 64'(credits), 64'd17);
    check("ovf_kept", 64'(ovf), 64'd1);
    check("tok_send_vld", 64'(bus.link_valid_o), 64'd0);

    // Disable during HOLD
    cyc();
    bus.link_ready_i = 1'b0;
    bus.req_valid_i = 4'b0100;
    set_data(2, 64'hC0FFEE);
    settle();
    check("dis_ready", 64'(bus.req_ready_o), 64'h4);
    cyc();
    bus.req_valid_i = 4'b1111;
    en = 1'b0;
    settle();
    check("dis_hold", 64'(bus.link_valid_o), 64'd1);
    check("dis_data", bus.link_data_o, 64'hC0FFEE);
    check("dis_noreq", 64'(bus.req_ready_o), 64'd0);
    cyc();
    bus.link_ready_i = 1'b1;
    settle();
    check("dis_finish", 64'(bus.link_valid_o), 64'd1);
    check("dis_nogrant", 64'(bus.req_ready_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      settle();
      check("dis_idle_v", 64'(bus.link_valid_o), 64'd0);
      check("dis_idle_r", 64'(bus.req_ready_o), 64'd0);
      check("dis_cred", 64'(credits), 64'd16);
    end

    // Reset while holding a word
    en = 1'b1;
    bus.link_ready_i = 1'b0;
    bus.req_valid_i = 4'b1000;
    set_data(3, 64'h3333);
    settle();
    check("re_dis_ready", 64'(bus.req_ready_o), 64'd0);
    cyc();
    settle();
    check("re_ready", 64'(bus.req_ready_o), 64'h8);
    cyc();
    settle();
    check("re_hold", 64'(bus.link_valid_o), 64'd1);
    check("re_gid", 64'(gid), 64'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.link_valid_o), 64'd0);
    check("mid_rst_cred", 64'(credits), 64'd64);
    check("mid_rst_gid", 64'(gid), 64'd0);
    check("mid_rst_data", bus.link_data_o, 64'd0);
    check("mid_rst_ready", 64'(bus.req_ready_o), 64'd0);
    check("sb_flushed", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
